adc_capture_sequencer: RTL and testbench

//  Arm/trigger/capture sequencer for the ADC sample path. Runs in the ADC sample clock

---
 rtl/adc_capture_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
// Arm/trigger/capture sequencer for the ADC sample path, running entirely in the
// ADC sample clock domain. It qualifies the trigger, waits a programmable
// post-trigger delay, then gives the DDR capture writer a clean go/valid window
// of exactly N samples and reports done/status.
//
// Optional feature macro: ADC_CAPTURE_TIMEOUT_EN
//   When defined, adds timeout_i / timed_out_o. ARMED then self-triggers after a
//   programmable number of cycles. When undefined, ARMED waits indefinitely.
module adc_capture_sequencer #(
    parameter int CNT_W     = 32,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 trig_i,
    input  logic                 trig_mode_i,
    input  logic                 trig_wait_i,
    input  logic [CNT_W-1:0]     delay_i,
    input  logic [CNT_W-1:0]     samples_i,
    input  logic                 ddr_stop_i,
`ifdef ADC_CAPTURE_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 timed_out_o,
`endif
    output logic                 capture_go_o,
    output logic                 sample_valid_o,
    output logic                 armed_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 stopped_early_o,
    output logic [CNT_W-1:0]     sample_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INACT,
        ARMED,
        DELAY,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             mode_lat;
    logic [CNT_W-1:0] delay_lat;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] sample_cnt;

    logic             trig_act;
    logic             fire;
    logic             arm_accept;
    logic             last_sample;

    // Reject degenerate widths at elaboration time
    if (CNT_W < 1 || TIMEOUT_W < 1) begin : g_bad_width
        $error("adc_capture_sequencer: CNT_W and TIMEOUT_W must be at least 1");
    end

    // Trigger polarity uses the mode captured at arm time, not the live input
    assign trig_act     = (trig_i == mode_lat);
    // Abort beats a coincident arm, and arm is only honoured from IDLE
    assign arm_accept   = (state == IDLE) && arm_i && !abort_i;
    // The sample presented on this edge is the last one of the run
    assign last_sample  = (sample_cnt == last_idx);
    assign sample_cnt_o = sample_cnt;

`ifdef ADC_CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_lat;
    logic [TIMEOUT_W-1:0] timer;
    logic                 timeout_hit;

    // Timer holds the number of the current ARMED cycle (1 on the first edge after entry)
    assign timeout_hit = (state == ARMED) && (timeout_lat != '0) && (timer == timeout_lat);
    assign fire        = trig_act || timeout_hit;

    // Auto-trigger timer: restarts on every ARMED entry, saturates, flags a timeout-driven start
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timeout_lat <= '0;
            timer       <= '0;
            timed_out_o <= 1'b0;
        end else begin
            if (arm_accept) begin
                timeout_lat <= timeout_i;
                timed_out_o <= 1'b0;
            end
            if ((state_next == ARMED) && (state != ARMED)) begin
                timer <= TIMEOUT_W'(1);
            end else if ((state == ARMED) && (timer != '1)) begin
                timer <= timer + TIMEOUT_W'(1);
            end
            if (timeout_hit && !trig_act && !abort_i) begin
                timed_out_o <= 1'b1;
            end
        end
    end
`else
    assign fire = trig_act;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_next = state;
        if (abort_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_i) begin
                        if (trig_wait_i && (trig_i == trig_mode_i)) begin
                            state_next = WAIT_INACT;
                        end else begin
                            state_next = ARMED;
                        end
                    end
                end
                WAIT_INACT: begin
                    if (!trig_act) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (fire) begin
                        if (delay_lat == '0) begin
                            state_next = CAPTURE;
                        end else begin
                            state_next = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (delay_cnt == '0) begin
                        state_next = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (last_sample || ddr_stop_i) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Registered status outputs, decoded from the next state so they align with it
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            capture_go_o   <= 1'b0;
            sample_valid_o <= 1'b0;
            armed_o        <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            capture_go_o   <= (state_next == CAPTURE);
            sample_valid_o <= (state_next == CAPTURE);
            armed_o        <= (state_next == WAIT_INACT) || (state_next == ARMED);
            busy_o         <= (state_next != IDLE);
            done_o         <= (state_next == DONE);
        end
    end

    // Run configuration snapshot taken when an arm is accepted; N of 0 behaves as 1
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mode_lat  <= 1'b0;
            delay_lat <= '0;
            last_idx  <= '0;
        end else if (arm_accept) begin
            mode_lat  <= trig_mode_i;
            delay_lat <= delay_i;
            last_idx  <= (samples_i == '0) ? '0 : (samples_i - CNT_W'(1));
        end
    end

    // Post-trigger delay counter: loaded with delay-1 on trigger, counts down to 0
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            delay_cnt <= '0;
        end else if ((state == ARMED) && (state_next == DELAY)) begin
            delay_cnt <= delay_lat - CNT_W'(1);
        end else if ((state == DELAY) && (state_next == DELAY)) begin
            delay_cnt <= delay_cnt - CNT_W'(1);
        end
    end

    // Sample counter and early-stop flag; both cleared on arm, held through abort
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sample_cnt      <= '0;
            stopped_early_o <= 1'b0;
        end else if (arm_accept) begin
            sample_cnt      <= '0;
            stopped_early_o <= 1'b0;
        end else if ((state == CAPTURE) && !abort_i) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (ddr_stop_i && !last_sample) begin
                stopped_early_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer
// Directed bench for adc_capture_sequencer. Stimulus pushes the expected
// valid/done events into a queue; a negedge monitor pops and compares them
// whenever the sequencer presents sample_valid_o or done_o.
// Define ADC_CAPTURE_TIMEOUT_EN for both files to exercise the timeout feature.
module tb_adc_capture_sequencer;

    localparam int CNT_W     = 32;
    localparam int TIMEOUT_W = 24;

    logic                 clk_i;
    logic                 reset_n_i;
    logic                 arm_i;
    logic                 abort_i;
    logic                 trig_i;
    logic                 trig_mode_i;
    logic                 trig_wait_i;
    logic [CNT_W-1:0]     delay_i;
    logic [CNT_W-1:0]     samples_i;
    logic                 ddr_stop_i;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_i;
    logic                 timed_out_o;
`endif
    logic                 capture_go_o;
    logic                 sample_valid_o;
    logic                 armed_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 stopped_early_o;
    logic [CNT_W-1:0]     sample_cnt_o;

    typedef struct {
        bit is_done;
        int cycle;
        int cnt;
        bit stopped;
    } event_t;

    event_t exp_q[$];
    event_t exp_ev;
    int     cyc = 0;
    int     tests_run = 0;
    int     tests_failed = 0;

    adc_capture_sequencer #(
        .CNT_W     (CNT_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .arm_i           (arm_i),
        .abort_i         (abort_i),
        .trig_i          (trig_i),
        .trig_mode_i     (trig_mode_i),
        .trig_wait_i     (trig_wait_i),
        .delay_i         (delay_i),
        .samples_i       (samples_i),
        .ddr_stop_i      (ddr_stop_i),
`ifdef ADC_CAPTURE_TIMEOUT_EN
        .timeout_i       (timeout_i),
        .timed_out_o     (timed_out_o),
`endif
        .capture_go_o    (capture_go_o),
        .sample_valid_o  (sample_valid_o),
        .armed_o         (armed_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .stopped_early_o (stopped_early_o),
        .sample_cnt_o    (sample_cnt_o)
    );

    // 100 MHz sample clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Edge counter: value seen at a negedge is the number of the preceding posedge
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue the valid cycles (and optionally the done pulse) of one run
    task automatic push_run(input int t, input int d, input int n_valid, input bit with_done,
                            input bit stopped);
        for (int i = 0; i < n_valid; i++) begin
            exp_q.push_back('{1'b0, t + d + i, 0, 1'b0});
        end
        if (with_done) begin
            exp_q.push_back('{1'b1, t + d + n_valid, n_valid, stopped});
        end
    endtask

    // Pulse arm with a configuration, then scramble the inputs to prove they were latched
    task automatic apply_stimulus(input logic mode, input logic wait_en, input int unsigned delay,
                                  input int unsigned n, output int arm_edge);
        @(negedge clk_i);
        arm_i       = 1'b1;
        trig_mode_i = mode;
        trig_wait_i = wait_en;
        delay_i     = delay;
        samples_i   = n;
        arm_edge    = cyc + 1;
        @(negedge clk_i);
        arm_i       = 1'b0;
        trig_mode_i = ~mode;
        trig_wait_i = ~wait_en;
        delay_i     = 32'd7;
        samples_i   = 32'd3;
    endtask

    // Called at a negedge: drive the trigger level and report the edge that samples it
    task automatic drive_trigger(input logic level, output int t);
        trig_i = level;
        t      = cyc + 1;
    endtask

    // Wait, with a cycle budget, for all expected events and for the sequencer to go idle
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check_output("run_finished", exp_q.size() + int'(busy_o), 0);
    endtask

    // Scoreboard monitor: compare every valid/done the DUT presents against the queue
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (sample_valid_o || done_o) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_output", {sample_valid_o, done_o}, 0);
                end else begin
                    exp_ev = exp_q.pop_front();
                    check_output("event_kind_done", done_o, exp_ev.is_done);
                    check_output("event_cycle", cyc, exp_ev.cycle);
                    check_output("capture_go_match", capture_go_o, sample_valid_o);
                    if (exp_ev.is_done) begin
                        check_output("done_sample_cnt", sample_cnt_o, exp_ev.cnt);
                        check_output("done_stopped_early", stopped_early_o, exp_ev.stopped);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cycle <= cyc) begin
                exp_ev = exp_q.pop_front();
                check_output("missed_event_cycle", cyc, exp_ev.cycle);
            end
        end
    end

    initial begin
        int t;
        int e;

        reset_n_i   = 1'b0;
        arm_i       = 1'b0;
        abort_i     = 1'b0;
        trig_i      = 1'b0;
        trig_mode_i = 1'b0;
        trig_wait_i = 1'b0;
        delay_i     = '0;
        samples_i   = '0;
        ddr_stop_i  = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
        timeout_i   = '0;
`endif

        // Reset values
        repeat (3) @(negedge clk_i);
        check_output("reset_busy", busy_o, 0);
        check_output("reset_armed", armed_o, 0);
        check_output("reset_go", capture_go_o, 0);
        check_output("reset_valid", sample_valid_o, 0);
        check_output("reset_done", done_o, 0);
        check_output("reset_stopped", stopped_early_o, 0);
        check_output("reset_sample_cnt", sample_cnt_o, 0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check_output("idle_busy", busy_o, 0);

        // Active-high, no wait, delay 0, N=4, trigger three cycles after arm
        $display("[TB] basic capture N=4");
        apply_stimulus(1'b1, 1'b0, 0, 4, e);
        check_output("t1_armed", armed_o, 1);
        check_output("t1_busy", busy_o, 1);
        repeat (2) @(negedge clk_i);
        drive_trigger(1'b1, t);
        push_run(t, 0, 4, 1'b1, 1'b0);
        @(negedge clk_i);
        trig_i = 1'b0;
        wait_idle(50);
        check_output("t1_final_cnt", sample_cnt_o, 4);

        // Wait-for-inactive: trigger already active at arm
        $display("[TB] wait for inactive");
        @(negedge clk_i);
        trig_i = 1'b1;
        apply_stimulus(1'b1, 1'b1, 2, 3, e);
        repeat (4) @(negedge clk_i);
        check_output("t2_armed_in_wait", armed_o, 1);
        check_output("t2_no_go_in_wait", capture_go_o, 0);
        trig_i = 1'b0;
        @(negedge clk_i);
        check_output("t2_armed_after_inactive", armed_o, 1);
        @(negedge clk_i);
        drive_trigger(1'b1, t);
        push_run(t, 2, 3, 1'b1, 1'b0);
        wait_idle(50);
        trig_i = 1'b0;

        // Active-low trigger, delay 10, N=1, with an ignored arm during the delay
        $display("[TB] delay 10 active-low");
        @(negedge clk_i);
        trig_i = 1'b1;
        apply_stimulus(1'b0, 1'b0, 10, 1, e);
        drive_trigger(1'b0, t);
        push_run(t, 10, 1, 1'b1, 1'b0);
        repeat (3) @(negedge clk_i);
        check_output("t3_in_delay_not_armed", armed_o, 0);
        arm_i     = 1'b1;
        samples_i = 32'd9;
        @(negedge clk_i);
        arm_i = 1'b0;
        wait_idle(50);
        check_output("t3_final_cnt", sample_cnt_o, 1);
        trig_i = 1'b0;

        // samples_i = 0 behaves as one sample
        $display("[TB] N=0 treated as 1");
        apply_stimulus(1'b1, 1'b0, 0, 0, e);
        drive_trigger(1'b1, t);
        push_run(t, 0, 1, 1'b1, 1'b0);
        @(negedge clk_i);
        trig_i = 1'b0;
        wait_idle(50);

        // ddr_stop_i ignored while armed, then stops the run at the 40th valid of 100
        $display("[TB] early stop at 40 of 100");
        apply_stimulus(1'b1, 1'b0, 0, 100, e);
        ddr_stop_i = 1'b1;
        @(negedge clk_i);
        ddr_stop_i = 1'b0;
        @(negedge clk_i);
        check_output("t4_stop_ignored_armed", stopped_early_o, 0);
        drive_trigger(1'b1, t);
        push_run(t, 0, 40, 1'b1, 1'b1);
        repeat (40) @(negedge clk_i);
        trig_i     = 1'b0;
        ddr_stop_i = 1'b1;
        @(negedge clk_i);
        ddr_stop_i = 1'b0;
        wait_idle(50);
        check_output("t4_stopped_sticky", stopped_early_o, 1);
        check_output("t4_cnt", sample_cnt_o, 40);

        // ddr_stop_i together with the last sample is a normal completion
        $display("[TB] stop coincident with last sample");
        apply_stimulus(1'b1, 1'b0, 0, 5, e);
        check_output("t4b_arm_clears_stopped", stopped_early_o, 0);
        check_output("t4b_arm_clears_cnt", sample_cnt_o, 0);
        drive_trigger(1'b1, t);
        push_run(t, 0, 5, 1'b1, 1'b0);
        repeat (5) @(negedge clk_i);
        trig_i     = 1'b0;
        ddr_stop_i = 1'b1;
        @(negedge clk_i);
        ddr_stop_i = 1'b0;
        wait_idle(50);

        // Abort during DELAY
        $display("[TB] abort in delay");
        apply_stimulus(1'b1, 1'b0, 20, 3, e);
        drive_trigger(1'b1, t);
        repeat (5) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        trig_i  = 1'b0;
        check_output("t5_abort_delay_busy", busy_o, 0);
        check_output("t5_abort_delay_cnt", sample_cnt_o, 0);
        repeat (25) @(negedge clk_i);

        // Abort during CAPTURE after ten valids: count holds at nine
        $display("[TB] abort in capture");
        apply_stimulus(1'b1, 1'b0, 0, 50, e);
        drive_trigger(1'b1, t);
        push_run(t, 0, 10, 1'b0, 1'b0);
        repeat (10) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        trig_i  = 1'b0;
        check_output("t5_abort_cap_busy", busy_o, 0);
        check_output("t5_abort_cap_go", capture_go_o, 0);
        check_output("t5_abort_cap_cnt", sample_cnt_o, 9);

        // Arm and abort in the same cycle: abort wins, count not cleared
        arm_i     = 1'b1;
        abort_i   = 1'b1;
        samples_i = 32'd5;
        @(negedge clk_i);
        arm_i   = 1'b0;
        abort_i = 1'b0;
        check_output("t5_arm_abort_busy", busy_o, 0);
        check_output("t5_arm_abort_armed", armed_o, 0);
        check_output("t5_arm_abort_cnt", sample_cnt_o, 9);
        wait_idle(10);

`ifdef ADC_CAPTURE_TIMEOUT_EN
        // Timeout of 50 cycles starts the capture without a trigger
        $display("[TB] timeout 50");
        timeout_i = 24'd50;
        apply_stimulus(1'b1, 1'b0, 0, 2, e);
        timeout_i = 24'd3;
        push_run(e + 50, 0, 2, 1'b1, 1'b0);
        wait_idle(100);
        check_output("t6_timed_out", timed_out_o, 1);

        // Timeout of 0 waits forever and arm clears the sticky flag
        timeout_i = '0;
        apply_stimulus(1'b1, 1'b0, 0, 2, e);
        check_output("t6_timed_out_cleared", timed_out_o, 0);
        repeat (120) @(negedge clk_i);
        check_output("t6_still_armed", armed_o, 1);
        check_output("t6_no_go", capture_go_o, 0);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        wait_idle(10);
`endif

        // Asynchronous reset mid-capture drops go immediately
        $display("[TB] async reset in capture");
        apply_stimulus(1'b1, 1'b0, 0, 20, e);
        drive_trigger(1'b1, t);
        push_run(t, 0, 5, 1'b0, 1'b0);
        repeat (5) @(negedge clk_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        check_output("t7_reset_go", capture_go_o, 0);
        check_output("t7_reset_valid", sample_valid_o, 0);
        check_output("t7_reset_busy", busy_o, 0);
        check_output("t7_reset_cnt", sample_cnt_o, 0);
        trig_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clk_i);

        check_output("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
